// File: rtl/strobe_sched.sv
// Multi-channel strobe divider with a round-robin, ready/valid scheduler onto one consumer.
// Overrun flag logic is built only when STROBE_SCHED_OVR_EN is defined; otherwise ovr reads 0.
module strobe_sched #(
  parameter int CH        = 4,
  parameter int DIV_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stri,
  input  logic [CH-1:0]           ch_en,
  input  logic [CH*DIV_WIDTH-1:0] div,
  output logic                    out_valid,
  output logic [$clog2(CH)-1:0]   out_ch,
  input  logic                    out_ready,
  output logic [CH-1:0]           ovr,
  input  logic [CH-1:0]           ovr_clr
);

  localparam int CW = $clog2(CH);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    if (int'(v) == CH - 1) return '0;
    return v + 1'b1;
  endfunction

  logic [DIV_WIDTH-1:0] cnt_q [CH];
  logic [DIV_WIDTH-1:0] cnt_d [CH];
  logic [CH-1:0]        term;
  logic [CH-1:0]        pend_q, pend_d;
  logic [CH-1:0]        clr_sel;
  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [CW-1:0]        out_ch_q, out_ch_d;
  logic [CW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        ptr;
  logic [CW-1:0]        sel;
  logic                 found;
  logic                 take;

  // Per-channel divider: terminal event when the count reaches the divisor.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      term[i]  = 1'b0;
      cnt_d[i] = cnt_q[i];
      if (!ch_en[i]) begin
        cnt_d[i] = '0;
      end else if (stri) begin
        if (cnt_q[i] == div[i*DIV_WIDTH +: DIV_WIDTH]) begin
          cnt_d[i] = '0;
          term[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Search starts at rr when idle, or just past the channel being handed over.
  always_comb begin
    int idx;
    idx   = 0;
    ptr   = (state_q == OFFER) ? wrap_inc(out_ch_q) : rr_q;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CH) idx = idx - CH;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_d        = rr_q;
    take        = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) take = 1'b1;
      end
      OFFER: begin
        if (out_ready) begin
          rr_d = wrap_inc(out_ch_q);
          if (found) begin
            take = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    if (take) begin
      state_d     = OFFER;
      out_valid_d = 1'b1;
      out_ch_d    = sel;
    end
    for (int i = 0; i < CH; i++) begin
      clr_sel[i] = take && (sel == CW'(i));
    end
  end

  // A fresh terminal event outranks the scheduler's clear of the same pend bit.
  always_comb begin
    pend_d = ch_en & (term | (pend_q & ~clr_sel));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_q        <= '0;
      pend_q      <= '0;
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_q        <= rr_d;
      pend_q      <= pend_d;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

`ifdef STROBE_SCHED_OVR_EN
  logic [CH-1:0] ovr_q, ovr_d;

  // An event landing on a still-pending, uncleared channel is dropped and flagged.
  always_comb begin
    ovr_d = (ovr_q & ~ovr_clr) | (term & pend_q & ~clr_sel);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovr_q <= '0;
    else        ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ^ovr_clr;
  assign ovr            = '0;
`endif

endmodule

// File: tb/tb_strobe_sched.sv
// Directed bench for strobe_sched (CH=4, DIV_WIDTH=10); overrun expectations follow
// whether STROBE_SCHED_OVR_EN is defined for the build.
module tb_strobe_sched;

  localparam int CH = 4;
  localparam int DW = 10;

`ifdef STROBE_SCHED_OVR_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            stri;
  logic [CH-1:0]   ch_en;
  logic [CH*DW-1:0] div;
  logic            out_valid;
  logic [1:0]      out_ch;
  logic            out_ready;
  logic [CH-1:0]   ovr;
  logic [CH-1:0]   ovr_clr;

  int checks = 0;
  int errors = 0;

  strobe_sched #(.CH(CH), .DIV_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stri      (stri),
    .ch_en     (ch_en),
    .div       (div),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stri = 1'b0; ch_en = '0; div = '0; out_ready = 1'b0; ovr_clr = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stri = 1'b0; ch_en = '0; div = '0; out_ready = 1'b0; ovr_clr = '0;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ch", 32'(out_ch), 0);
    check("rst_ovr", 32'(ovr), 0);

    // Single channel, divide by 4: offers at cycles 5 and 9.
    rst_n = 1'b1; div[0 +: DW] = 10'd3; ch_en = 4'b0001; stri = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("div4_valid_c%0d", k), 32'(out_valid), ((k == 5) || (k == 9)) ? 1 : 0);
      if (k == 5 || k == 9) check($sformatf("div4_ch_c%0d", k), 32'(out_ch), 0);
    end

    // All channels divide by 1: round-robin back-to-back, overruns everywhere.
    do_reset();
    ch_en = 4'hF; stri = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) check("rr_idle_c1", 32'(out_valid), 0);
      if (k >= 2) begin
        check($sformatf("rr_valid_c%0d", k), 32'(out_valid), 1);
        check($sformatf("rr_ch_c%0d", k), 32'(out_ch), 32'((k - 2) % 4));
      end
      if (k == 2) check("rr_ovr_setwins", 32'(ovr), OVR_ON ? 32'hE : 0);
      if (k == 3) check("rr_ovr_all", 32'(ovr), OVR_ON ? 32'hF : 0);
    end

    // Channel 1 held off for 10 cycles; enable drops mid-offer.
    do_reset();
    ch_en = 4'b0010; stri = 1'b1; out_ready = 1'b0;
    tick();
    stri = 1'b0;
    check("hold_c1_valid", 32'(out_valid), 0);
    for (int k = 2; k <= 11; k++) begin
      tick();
      check($sformatf("hold_valid_c%0d", k), 32'(out_valid), 1);
      check($sformatf("hold_ch_c%0d", k), 32'(out_ch), 1);
      if (k == 5) ch_en = 4'b0000;
    end
    out_ready = 1'b1;
    tick();
    check("hold_accepted", 32'(out_valid), 0);

    // Channel 2 divide by 2 with consumer stalled: overrun, clear, overrun-beats-clear.
    do_reset();
    div[2*DW +: DW] = 10'd1; ch_en = 4'b0100; stri = 1'b1; out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 2) check($sformatf("ovr_valid_c%0d", k), 32'(out_valid), 0);
      if (k == 3) begin
        check("ovr_valid_c3", 32'(out_valid), 1);
        check("ovr_ch_c3", 32'(out_ch), 2);
      end
      if (k == 4 || k == 5) check($sformatf("ovr_none_c%0d", k), 32'(ovr), 0);
      if (k == 6) check("ovr_set_c6", 32'(ovr), OVR_ON ? 32'h4 : 0);
    end
    stri = 1'b0; ovr_clr = 4'b0100;
    tick();
    check("ovr_cleared", 32'(ovr), 0);
    ovr_clr = '0; stri = 1'b1;
    tick();
    check("ovr_quiet_c8", 32'(ovr), 0);
    ovr_clr = 4'b0100;
    tick();
    ovr_clr = '0;
    check("ovr_beats_clr", 32'(ovr), OVR_ON ? 32'h4 : 0);
    check("ovr_still_offer", 32'(out_valid), 1);

    // Reset while offering: offer abandoned, counting restarts from zero.
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ovr", 32'(ovr), 0);
    check("midrst_ch", 32'(out_ch), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("restart_valid_c%0d", k), 32'(out_valid), ((k == 3) || (k == 5)) ? 1 : 0);
      if (k == 3) check("restart_ch_c3", 32'(out_ch), 2);
      if (k == 1) check("restart_ovr_c1", 32'(ovr), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
